// File: rtl/sb_rx_payload_decoder_pkg.sv
// Shared types and decode rules for the sideband RX payload decoder.
// Queue entries carry a 16-bit payload; the top zero-extends it to OUT_W.
package sb_rx_pkg;

  localparam int unsigned PAYLOAD_W = 16;

  localparam logic [7:0] MSG_81 = 8'h81;
  localparam logic [7:0] MSG_85 = 8'h85;
  localparam logic [7:0] MSG_8A = 8'h8A;
  localparam logic [7:0] MSG_A5 = 8'hA5;
  localparam logic [7:0] MSG_AA = 8'hAA;

  // Subcode nibble sets as bitmasks indexed by the nibble value
  localparam logic [15:0] SN_SET_85    = 16'h04A2;  // {1,5,7,A}
  localparam logic [15:0] SN_SET_81_8A = 16'h0808;  // {3,B}

  typedef struct packed {
    logic [7:0]           code;
    logic [7:0]           subcode;
    logic [PAYLOAD_W-1:0] payload;
  } sb_rx_entry_t;

  typedef struct packed {
    logic                 hit;
    logic [PAYLOAD_W-1:0] payload;
  } sb_rx_decode_t;

  // Extract the message-specific field; hit=0 when code/subcode is unsupported
  function automatic sb_rx_decode_t sb_rx_decode(input logic [7:0]  code,
                                                 input logic [3:0]  sn,
                                                 input logic [15:0] lo,
                                                 input logic        b59);
    sb_rx_decode_t r;
    r = '0;
    case (code)
      MSG_85: begin
        r.hit     = SN_SET_85[sn];
        r.payload = PAYLOAD_W'({b59, lo[11], lo[7:6], lo[0]});
      end
      MSG_81, MSG_8A: begin
        r.hit     = SN_SET_81_8A[sn];
        r.payload = lo;
      end
      MSG_A5: begin
        r.hit     = (sn == 4'h0);
        r.payload = PAYLOAD_W'(lo[10:0]);
      end
      MSG_AA: begin
        r.hit     = (sn == 4'h0) || (sn == 4'hF);
        r.payload = (sn == 4'hF) ? lo : PAYLOAD_W'(lo[10:0]);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_rx_payload_decoder_if.sv
// Output handshake bus of the sideband RX payload decoder.
interface sb_rx_payload_decoder_if #(
  parameter int unsigned OUT_W = 16
) ();
  logic             valid;
  logic             ready;
  logic [OUT_W-1:0] data;
  logic [7:0]       msg_code;
  logic [7:0]       msg_subcode;

  modport master (output valid, data, msg_code, msg_subcode, input ready);
  modport slave  (input valid, data, msg_code, msg_subcode, output ready);
endinterface

// File: rtl/sb_rx_payload_decoder_sync_fifo.sv
// Single-clock FIFO with flush; a push into a full queue succeeds only with a same-cycle pop.
module sb_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == LW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;
  assign rdata = mem[rd_ptr];
  assign level = count;

  // Storage is reset so the head word reads zero out of reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(wr_ok) - LW'(rd_ok);
    end
  end

endmodule

// File: rtl/sb_rx_payload_decoder.sv
// Decodes sideband header/data phases into tagged payloads and queues them for the
// link-training consumers, with overflow and unsupported-message reporting.
module sb_rx_payload_decoder
  import sb_rx_pkg::*;
#(
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PASS_UNKNOWN = 1'b0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_header_is_valid_on_bus,
  input  logic                        i_data_enable,
  input  logic [63:0]                 i_data,
  input  logic                        i_flush,
  sb_rx_payload_decoder_if.master     out_if,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_overflow,
  output logic                        o_decode_err
);

  logic [7:0]    code_q;
  logic [7:0]    subcode_q;
  sb_rx_decode_t dec_c;
  sb_rx_entry_t  entry_c;
  sb_rx_entry_t  head;
  logic          push_c;
  logic          pop_c;
  logic          full;
  logic          empty;
  logic          unused_data;

  assign unused_data = ^{i_data[63:60], i_data[58:40], i_data[31:22]};

  // Header capture; a data phase in the same cycle still sees the previous header
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_q    <= '0;
      subcode_q <= '0;
    end else if (i_header_is_valid_on_bus) begin
      code_q    <= i_data[21:14];
      subcode_q <= i_data[39:32];
    end
  end

  always_comb begin
    dec_c           = sb_rx_decode(code_q, subcode_q[3:0], i_data[15:0], i_data[59]);
    entry_c.code    = code_q;
    entry_c.subcode = subcode_q;
    entry_c.payload = dec_c.hit ? dec_c.payload : i_data[15:0];
    push_c          = i_data_enable && (dec_c.hit || PASS_UNKNOWN) && !i_flush;
    pop_c           = !empty && out_if.ready;
  end

  sb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(sb_rx_entry_t))
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (i_flush),
    .wdata   (entry_c),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (o_level)
  );

  assign out_if.valid       = !empty;
  assign out_if.data        = OUT_W'(head.payload);
  assign out_if.msg_code    = head.code;
  assign out_if.msg_subcode = head.subcode;

  // Sticky overflow and one-cycle drop pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow   <= 1'b0;
      o_decode_err <= 1'b0;
    end else begin
      if (i_flush)                         o_overflow <= 1'b0;
      else if (push_c && full && !pop_c)   o_overflow <= 1'b1;
      o_decode_err <= i_data_enable && !dec_c.hit && !PASS_UNKNOWN;
    end
  end

endmodule

// File: tb/tb_sb_rx_payload_decoder.sv
// Randomized scoreboard bench for sb_rx_payload_decoder (OUT_W=16, depth 4, unknowns dropped).
module tb_sb_rx_payload_decoder;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]  code;
    logic [7:0]  sub;
    logic [15:0] payload;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hdr_v = 1'b0;
  logic        den = 1'b0;
  logic [63:0] din = '0;
  logic        flush = 1'b0;
  logic [2:0]  level;
  logic        overflow;
  logic        decode_err;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  int          mcount = 0;
  logic        movf = 1'b0;
  logic        merr = 1'b0;
  logic [7:0]  mcode = '0;
  logic [7:0]  msub = '0;

  sb_rx_payload_decoder_if #(.OUT_W(16)) bus ();

  sb_rx_payload_decoder #(.OUT_W(16), .FIFO_DEPTH(DEPTH), .PASS_UNKNOWN(1'b0)) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_header_is_valid_on_bus (hdr_v),
    .i_data_enable            (den),
    .i_data                   (din),
    .i_flush                  (flush),
    .out_if                   (bus),
    .o_level                  (level),
    .o_overflow               (overflow),
    .o_decode_err             (decode_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the message table
  function automatic bit ref_decode(input logic [7:0] c, input logic [7:0] s,
                                    input logic [63:0] d, output logic [15:0] p);
    int sn;
    sn = int'(s & 8'h0F);
    p  = '0;
    if (c == 8'h85 && (sn == 1 || sn == 5 || sn == 7 || sn == 10)) begin
      p = 16'(((d >> 59) & 1) * 16 + ((d >> 11) & 1) * 8 + ((d >> 6) & 3) * 2 + (d & 1));
      return 1'b1;
    end
    if ((c == 8'h81 || c == 8'h8A) && (sn == 3 || sn == 11)) begin
      p = 16'(d % 65536);
      return 1'b1;
    end
    if ((c == 8'hA5 || c == 8'hAA) && sn == 0) begin
      p = 16'(d % 2048);
      return 1'b1;
    end
    if (c == 8'hAA && sn == 15) begin
      p = 16'(d % 65536);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] hdr_word(input logic [7:0] c, input logic [7:0] s);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[21:14] = c;
    w[39:32] = s;
    return w;
  endfunction

  // Drive one cycle, advance the model, then check status after the edge
  task automatic cycle(input logic h, input logic de, input logic [63:0] d,
                       input logic fl, input logic rdy);
    logic [15:0] p;
    bit          hit;
    bit          pop_m;
    exp_t        e;
    hdr_v     = h;
    den       = de;
    din       = d;
    flush     = fl;
    bus.ready = fl ? 1'b0 : rdy;
    hit   = ref_decode(mcode, msub, d, p);
    pop_m = (mcount > 0) && bus.ready;
    merr  = de && !hit;
    if (fl) begin
      sb.delete();
      mcount = 0;
      movf   = 1'b0;
    end else begin
      if (de && hit) begin
        if (mcount == DEPTH && !pop_m) movf = 1'b1;
        else begin
          e.code = mcode; e.sub = msub; e.payload = p;
          sb.push_back(e);
          mcount++;
        end
      end
      if (pop_m) mcount--;
    end
    if (h) begin
      mcode = d[21:14];
      msub  = d[39:32];
    end
    @(posedge clk);
    #1;
    chk("level", 64'(level), 64'(mcount));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("decode_err", 64'(decode_err), 64'(merr));
    chk("valid", 64'(bus.valid), 64'(mcount != 0));
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 64'h0, 1'b0, rdy);
  endtask

  task automatic msg(input logic [7:0] c, input logic [7:0] s, input logic [63:0] d,
                     input logic rdy);
    cycle(1'b1, 1'b0, hdr_word(c, s), 1'b0, rdy);
    cycle(1'b0, 1'b1, d, 1'b0, rdy);
  endtask

  // Monitor: every accepted head entry must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && bus.valid && bus.ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output data=0x%0h code=0x%0h", bus.data, bus.msg_code);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 64'(bus.data), 64'(e.payload));
        chk("out_code", 64'(bus.msg_code), 64'(e.code));
        chk("out_subcode", 64'(bus.msg_subcode), 64'(e.sub));
      end
    end
  end

  initial begin
    bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.valid), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);
    chk("rst_data", 64'(bus.data), 64'h0);
    rst_n = 1'b1;
    idle(1'b0);

    // 0x85/0x01 field gather
    msg(8'h85, 8'h01, 64'h0800_0000_0000_08C1, 1'b0);
    chk("d85_valid", 64'(bus.valid), 64'h1);
    chk("d85_data", 64'(bus.data), 64'h001F);
    chk("d85_code", 64'(bus.msg_code), 64'h85);
    idle(1'b1);

    // 0xAA full-width and 11-bit forms
    msg(8'hAA, 8'h0F, 64'h1234, 1'b0);
    chk("aaf_data", 64'(bus.data), 64'h1234);
    idle(1'b1);
    msg(8'hAA, 8'h00, 64'h0FFF, 1'b0);
    chk("aa0_data", 64'(bus.data), 64'h07FF);
    idle(1'b1);

    // Unsupported message is dropped and flagged for one cycle
    msg(8'h99, 8'h00, 64'hDEAD_BEEF, 1'b0);
    chk("unk_err", 64'(decode_err), 64'h1);
    chk("unk_level", 64'(level), 64'h0);
    idle(1'b0);
    chk("unk_err_clear", 64'(decode_err), 64'h0);

    // Five messages into a stalled depth-4 queue
    cycle(1'b1, 1'b0, hdr_word(8'hA5, 8'h30), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 64'(100 + i), 1'b0, 1'b0);
    chk("full_level", 64'(level), 64'h4);
    chk("full_overflow", 64'(overflow), 64'h1);
    // Push and pop together while full
    cycle(1'b0, 1'b1, 64'h777, 1'b0, 1'b1);
    chk("pp_level", 64'(level), 64'h4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drained_level", 64'(level), 64'h0);
    chk("drained_overflow_sticky", 64'(overflow), 64'h1);
    cycle(1'b0, 1'b1, 64'h55, 1'b1, 1'b0);
    chk("flush_level", 64'(level), 64'h0);
    chk("flush_overflow", 64'(overflow), 64'h0);

    // Header and data enable together: data uses old header
    cycle(1'b1, 1'b1, hdr_word(8'h81, 8'h03), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, hdr_word(8'h8A, 8'hFB), 1'b0, 1'b0);

    // Reset mid-operation with queued entries
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 64'(i + 9), 1'b0, 1'b0);
    hdr_v = 1'b0; den = 1'b0; flush = 1'b0; bus.ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(bus.valid), 64'h0);
    chk("mrst_level", 64'(level), 64'h0);
    chk("mrst_overflow", 64'(overflow), 64'h0);
    chk("mrst_data", 64'(bus.data), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete(); mcount = 0; movf = 1'b0; merr = 1'b0; mcode = '0; msub = '0;
    idle(1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] c, s;
      logic [7:0] codes [7];
      logic [3:0] nibs [9];
      logic       stall;
      codes = '{8'h81, 8'h85, 8'h8A, 8'hA5, 8'hAA, 8'h99, 8'($urandom)};
      nibs  = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h7, 4'hA, 4'hB, 4'hF, 4'($urandom)};
      c = codes[$urandom_range(6, 0)];
      s = {4'($urandom), nibs[$urandom_range(8, 0)]};
      stall = ((n / 60) % 2) == 1;
      cycle(($urandom % 3) == 0, ($urandom % 2) == 0, hdr_word(c, s),
            ($urandom % 80) == 0, stall ? (($urandom % 6) == 0) : (($urandom % 4) != 0));
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("final_sb_empty", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
